fir_out_i2s_tx: RTL and testbench
=================================

# fir_out_i2s_tx

Output-side transmitter for the audio low-pass path: accepts 32-bit signed filter results from `fir_filter_structural`, rounds and saturates them to 16-bit PCM, and buffers them in a small FIFO. It then serializes each sample onto a left-justified I2S-style serial link (`bclk`/`lrclk`/`sdata`) toward the DAC. The same sample is sent on both channels, so the filtered mono audio leaves the FPGA as a serial stream rather than through the simulation file dump.

## Interface
- `IN_W`, 32, width of the filter result input
- `OUT_W`, 16, PCM word width per channel slot (fixed at 16; slot = 16 bclk)
- `BCLK_DIV`, 4, clk cycles per bclk half-period (≥2)
- `FIFO_DEPTH`, 4, sample FIFO entries (power of 2)

- `clk` in 1: system clock; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `y_in` in IN_W: signed filter result (Q-format; integer part in [31:16])
- `y_valid` in 1: `y_in` valid this cycle
- `y_ready` out 1: FIFO can accept; `!full`
- `clr_flags` in 1: synchronous clear of sticky flags
- `bclk` out 1: serial bit clock
- `lrclk` out 1: 0 = left slot, 1 = right slot
- `sdata` out 1: serial data, MSB first
- `fifo_level` out clog2(FIFO_DEPTH)+1: current occupancy
- `overflow` out 1: sticky; a valid sample was dropped while full
- `underrun` out 1: sticky; frame started with FIFO empty

## Operation
- **Rounding:** `r = y_in[31:16] + y_in[15]`, computed in 17 bits. If `r > 0x7FFF`, the result saturates to `0x7FFF`. Negative values cannot overflow. This is round-half-up on bit 15.
- **Push:** when `y_valid && y_ready`, the rounded word is written to the FIFO. When `y_valid && !y_ready`, the sample is dropped and `overflow` is set.
- **Bit clock:**
  - `div_cnt` runs 0..BCLK_DIV-1.
  - At terminal count, `bclk` toggles and `div_cnt` wraps to 0.
  - A falling toggle (1→0) is a shift event.
- **Slot counter:** `slot` is 5 bits, 0..31, and advances on each shift event, wrapping 31→0.
- **Frame start:** the shift event that sets `slot`=0.
  - If the FIFO is non-empty, pop the head into `word`.
  - If it is empty, load `word`=0 and set `underrun`.
- **Serial outputs** are registered and updated only on shift events:
  - `lrclk = slot[4]`
  - `sdata = word[15 - slot[3:0]]`
  - Left and right slots carry the identical word. Format is left-justified: the MSB coincides with the `lrclk` edge, with no I2S one-bit delay.
- **Simultaneous push and pop:** allowed in the same cycle. `fifo_level` is unchanged. When full, `y_ready` is 0, so the push is rejected regardless of a same-cycle pop.
- **Pop while empty with a same-cycle push:** the pop sees empty and sends 0 with `underrun` set. The pushed sample is served at the next frame.
- **Flag priority:** `clr_flags` clears `overflow` and `underrun`, but a set event in the same cycle wins (flag stays 1).
- **Reset** (async, any time, including mid-frame):
  - Serial outputs: `bclk`=0, `lrclk`=0, `sdata`=0.
  - Counters: `div_cnt`=0, `slot`=31, so the first shift event starts a frame.
  - FIFO and flags: FIFO emptied, `fifo_level`=0, `y_ready`=1, `overflow`=0, `underrun`=0, `word`=0.
  - The partial frame is discarded.

## Timing
- First `bclk` rise occurs BCLK_DIV cycles after reset release. The first shift event (frame 0, slot 0) follows at 2·BCLK_DIV cycles.
- Shift events recur every 2·BCLK_DIV cycles. A frame lasts 64·BCLK_DIV cycles (256 at default).
- `sdata`/`lrclk` change on the same clk edge as the bclk falling edge, so they are stable at the bclk rise.
- Push latency: a pushed word is visible in `fifo_level` the next cycle. The earliest it is transmitted is the next frame start.
- Sustained input rate must not exceed one sample per frame. Excess samples back-pressure through `y_ready`, then overflow if `y_valid` is held regardless.

## Test plan
- **Reset defaults:** assert `rst` mid-stream → all outputs at reset values on the same cycle (async). After release, first `bclk` rise at cycle 4 and first shift event at cycle 8, with `lrclk`=0.
- **Rounding/saturation:**
  - `y_in`=0x1234_8000 → `0x1235`
  - `y_in`=0x7FFF_FFFF → `0x7FFF`
  - `y_in`=0xFFFF_7FFF → `0xFFFF`
  - `y_in`=0x8000_0000 → `0x8000`
  - All are checked by capturing `sdata` on bclk rise in both slots.
- **Framing:** push 0xA5C3 before frame 0 → slots 0-15 and 16-31 each read `1010010111000011` MSB first. `lrclk` is 0 for slots 0-15 and 1 for slots 16-31. Frame length is 256 clk.
- **Underrun:** no pushes → `sdata` stays 0 and `underrun`=1 after the first frame start. `clr_flags` pulse clears it. Push one sample → it is sent at the next frame.
- **Overflow/back-pressure:** push 5 samples back-to-back with no frame start → `y_ready`=0 after the 4th, `fifo_level`=4, 5th dropped, `overflow`=1. At the next frame start, `fifo_level`=3 and `y_ready`=1.
- **Concurrency:** push on the exact cycle of a pop with level 2 → level stays 2 and order is preserved. Push on a pop cycle with level 0 → 0 sent, `underrun`=1, pushed word sent the following frame.

Source files
------------

// File: rtl/fir_out_i2s_tx_if.sv
// Sample stream from the FIR filter into the I2S transmitter.
// The filter side drives master, the transmitter consumes through slave.
interface fir_out_i2s_tx_if #(
    parameter int IN_W = 32
) ();
    logic [IN_W-1:0] y_in;
    logic            y_valid;
    logic            y_ready;

    modport master (
        output y_in,
        output y_valid,
        input  y_ready
    );

    modport slave (
        input  y_in,
        input  y_valid,
        output y_ready
    );
endinterface

// File: rtl/fir_out_i2s_tx.sv
// Output transmitter for the audio low-pass path.
// Rounds/saturates 32-bit filter results to 16-bit PCM, buffers them in a
// small FIFO and sends each sample on both slots of a left-justified
// bclk/lrclk/sdata link. One FIFO entry is consumed per 32-slot frame.
module fir_out_i2s_tx #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fir_out_i2s_tx_if.slave               y,
    input  logic                          clr_flags,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [OUT_W-1:0] PCM_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    // Rounding: add bit just below the kept field; only the largest positive
    // value can carry into the sign, which shows up as r_sum[top:top-1]=01.
    logic [OUT_W-1:0] y_hi;
    logic             y_half;
    logic [OUT_W:0]   r_sum;
    logic [OUT_W-1:0] pcm;

    assign y_hi   = y.y_in[IN_W-1 -: OUT_W];
    assign y_half = y.y_in[IN_W-OUT_W-1];
    assign r_sum  = {y_hi[OUT_W-1], y_hi} + {{OUT_W{1'b0}}, y_half};
    assign pcm    = (r_sum[OUT_W:OUT_W-1] == 2'b01) ? PCM_MAX : r_sum[OUT_W-1:0];

    // FIFO storage and control
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;

    assign full      = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign empty     = (fifo_level == '0);
    assign y.y_ready = ~full;
    assign push      = y.y_valid & ~full;
    assign drop      = y.y_valid & full;

    // Bit clock and serializer state
    logic [DW-1:0]    div_cnt;
    logic [4:0]       slot;
    logic [4:0]       slot_next;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] word_load;
    logic [OUT_W-1:0] word_cur;
    logic             tc;
    logic             shift;
    logic             frame_start;

    assign tc          = (div_cnt == DW'(BCLK_DIV - 1));
    assign shift       = tc & bclk;
    assign slot_next   = slot + 5'd1;
    assign frame_start = shift & (slot == 5'd31);
    assign pop         = frame_start & ~empty;
    assign word_load   = empty ? '0 : mem[rd_ptr];
    // At a frame start the MSB must come from the freshly popped word.
    assign word_cur    = frame_start ? word_load : word;

    // Divide clk down to bclk; a falling toggle is the shift event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Advance slot and update lrclk/sdata on each shift event; 15-slot is ~slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot  <= 5'd31;
            word  <= '0;
            lrclk <= 1'b0;
            sdata <= 1'b0;
        end else if (shift) begin
            slot  <= slot_next;
            word  <= word_cur;
            lrclk <= slot_next[4];
            sdata <= word_cur[~slot_next[3:0]];
        end
    end

    // FIFO data array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pcm;
        end
    end

    // FIFO pointers and occupancy; a push and a pop together leave the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky flags; a set event outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (frame_start && empty) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_i2s_tx.sv
// Directed bench for fir_out_i2s_tx at default parameters.
// Time is tracked as "pos" = rising edges since reset release; everything is
// sampled/driven on the falling clk edge. Frame f starts at pos 256*f+8 and
// slot k of that frame is sampled at the bclk rise, pos start+8*k+4.
module tb_fir_out_i2s_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_flags = 1'b0;
    logic       bclk;
    logic       lrclk;
    logic       sdata;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       underrun;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;

    fir_out_i2s_tx_if #(.IN_W(32)) yif ();

    fir_out_i2s_tx #(
        .IN_W       (32),
        .OUT_W      (16),
        .BCLK_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .y          (yif),
        .clr_flags  (clr_flags),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int target);
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic push_word(input logic [31:0] v);
        yif.y_in    = v;
        yif.y_valid = 1'b1;
        go_to(pos + 1);
        yif.y_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check(tag, {26'd0, bclk, lrclk, sdata, yif.y_ready, overflow, underrun}, 32'h4);
        check({tag, "_level"}, 32'(fifo_level), 32'h0);
    endtask

    task automatic capture_frame(input int fs, input string tag, input logic [15:0] exp);
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] lrv;
        logic [31:0] bck;
        l   = '0;
        r   = '0;
        lrv = '0;
        bck = '0;
        for (int k = 0; k < 32; k++) begin
            go_to(fs + 8 * k + 4);
            lrv[k] = lrclk;
            bck[k] = bclk;
            if (k < 16) l = {l[14:0], sdata};
            else        r = {r[14:0], sdata};
        end
        check({tag, "_left"}, 32'(l), 32'(exp));
        check({tag, "_right"}, 32'(r), 32'(exp));
        check({tag, "_lrclk"}, lrv, 32'hFFFF_0000);
        check({tag, "_bclk_hi"}, bck, 32'hFFFF_FFFF);
    endtask

    initial begin
        yif.y_in    = '0;
        yif.y_valid = 1'b0;

        // Reset values and first frame timing
        repeat (3) @(negedge clk);
        check_reset("reset_init");
        rst = 1'b0;
        pos = 0;

        go_to(1);
        push_word(32'hA5C3_0000);
        check("level_after_push", 32'(fifo_level), 32'd1);
        go_to(3);
        check("bclk_pre_rise", 32'(bclk), 32'd0);
        go_to(4);
        check("bclk_first_rise", 32'(bclk), 32'd1);
        check("lrclk_first_rise", 32'(lrclk), 32'd0);
        go_to(7);
        check("bclk_before_shift", 32'(bclk), 32'd1);
        go_to(8);
        check("bclk_first_fall", 32'(bclk), 32'd0);
        check("level_after_pop", 32'(fifo_level), 32'd0);
        check("underrun_frame0", 32'(underrun), 32'd0);
        capture_frame(8, "frame_a5c3", 16'hA5C3);

        // Frame length and underrun
        go_to(263);
        check("lrclk_end_frame0", 32'(lrclk), 32'd1);
        check("underrun_before_f1", 32'(underrun), 32'd0);
        go_to(264);
        check("lrclk_frame1_start", 32'(lrclk), 32'd0);
        check("underrun_set", 32'(underrun), 32'd1);
        capture_frame(264, "frame_underrun", 16'h0000);
        clr_flags = 1'b1;
        go_to(pos + 1);
        clr_flags = 1'b0;
        check("underrun_cleared", 32'(underrun), 32'd0);

        // Rounding and saturation, one sample per frame
        push_word(32'h1234_8000);
        go_to(520);
        check("underrun_f2", 32'(underrun), 32'd0);
        capture_frame(520, "round_up", 16'h1235);
        push_word(32'h7FFF_FFFF);
        capture_frame(776, "sat_pos", 16'h7FFF);
        push_word(32'hFFFF_7FFF);
        capture_frame(1032, "neg_one", 16'hFFFF);
        push_word(32'h8000_0000);
        capture_frame(1288, "most_neg", 16'h8000);
        go_to(1544);
        check("underrun_f6", 32'(underrun), 32'd1);

        // Back-pressure and overflow
        go_to(1550);
        check("overflow_before", 32'(overflow), 32'd0);
        check("ready_before", 32'(yif.y_ready), 32'd1);
        yif.y_valid = 1'b1;
        yif.y_in = 32'h1111_0000; go_to(1551);
        yif.y_in = 32'h2222_0000; go_to(1552);
        yif.y_in = 32'h3333_0000; go_to(1553);
        check("level_3", 32'(fifo_level), 32'd3);
        check("ready_at_3", 32'(yif.y_ready), 32'd1);
        yif.y_in = 32'h4444_0000; go_to(1554);
        check("level_full", 32'(fifo_level), 32'd4);
        check("ready_full", 32'(yif.y_ready), 32'd0);
        check("overflow_not_yet", 32'(overflow), 32'd0);
        yif.y_in = 32'h5555_0000; go_to(1555);
        yif.y_valid = 1'b0;
        check("level_after_drop", 32'(fifo_level), 32'd4);
        check("overflow_set", 32'(overflow), 32'd1);
        go_to(1800);
        check("level_after_frame", 32'(fifo_level), 32'd3);
        check("ready_after_frame", 32'(yif.y_ready), 32'd1);
        capture_frame(1800, "fifo_v1", 16'h1111);
        capture_frame(2056, "fifo_v2", 16'h2222);

        // Push on the pop edge with level 2
        go_to(2311);
        check("level_before_concurrent", 32'(fifo_level), 32'd2);
        push_word(32'h6666_0000);
        check("level_concurrent", 32'(fifo_level), 32'd2);
        capture_frame(2312, "fifo_v3", 16'h3333);
        capture_frame(2568, "fifo_v4", 16'h4444);
        capture_frame(2824, "fifo_v6", 16'h6666);
        go_to(3077);
        check("level_drained", 32'(fifo_level), 32'd0);
        clr_flags = 1'b1;
        go_to(3078);
        clr_flags = 1'b0;
        check("overflow_cleared", 32'(overflow), 32'd0);
        check("underrun_cleared2", 32'(underrun), 32'd0);

        // Push on the pop edge with level 0, with a clear pulse on the same edge
        go_to(3335);
        clr_flags = 1'b1;
        push_word(32'h7777_0000);
        clr_flags = 1'b0;
        check("underrun_set_wins", 32'(underrun), 32'd1);
        check("level_push_on_empty_pop", 32'(fifo_level), 32'd1);
        capture_frame(3336, "empty_pop_zero", 16'h0000);
        go_to(3592);
        check("level_served", 32'(fifo_level), 32'd0);
        capture_frame(3592, "late_served", 16'h7777);

        // Asynchronous reset in the right slot of a frame
        go_to(3899);
        push_word(32'h0AAA_0000);
        go_to(4012);
        check("pre_reset_bclk", 32'(bclk), 32'd1);
        check("pre_reset_lrclk", 32'(lrclk), 32'd1);
        check("pre_reset_level", 32'(fifo_level), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset("reset_async");
        repeat (2) @(negedge clk);
        check_reset("reset_held");
        rst = 1'b0;
        pos = 0;
        go_to(3);
        check("rerun_bclk_pre_rise", 32'(bclk), 32'd0);
        go_to(4);
        check("rerun_bclk_rise", 32'(bclk), 32'd1);
        go_to(7);
        check("rerun_underrun_pre", 32'(underrun), 32'd0);
        go_to(8);
        check("rerun_underrun", 32'(underrun), 32'd1);
        check("rerun_sdata", 32'(sdata), 32'd0);
        check("rerun_lrclk", 32'(lrclk), 32'd0);
        check("rerun_level", 32'(fifo_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
